// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: program counter, instruction-memory address and the
// IF/ID register. Branches resolve in ID with one delay slot, optionally squashed.
module fetch_unit #(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter bit          FLUSH_ON_BRANCH = 1'b0,
  parameter logic [31:0] NOP_WORD        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        BrTaken,
  input  logic        UncondBr,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic [63:0] pc_id,
  output logic [63:0] br_target
);

  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_id_q, pc_id_d;

  logic [63:0] br_offset;
  logic [63:0] pc_plus4;

  // Offsets are word counts; the 2-bit shift is folded into the concatenation.
  always_comb begin
    if (UncondBr) begin
      br_offset = {{36{instr_q[25]}}, instr_q[25:0], 2'b00};
    end else begin
      br_offset = {{43{instr_q[23]}}, instr_q[23:5], 2'b00};
    end
  end

  assign br_target = pc_id_q + br_offset;
  assign pc_plus4  = pc_q + 64'd4;

  // Stall holds everything, so a taken branch held in ID redirects exactly once.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc_id_d = pc_id_q;
    if (!stall) begin
      pc_d    = BrTaken ? br_target : pc_plus4;
      pc_id_d = pc_q;
      if (FLUSH_ON_BRANCH && BrTaken) begin
        instr_d = NOP_WORD;
      end else begin
        instr_d = imem_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc_id_q <= RESET_PC;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc_id_q <= pc_id_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign pc_id       = pc_id_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance without and one with delay-slot squashing,
// both reading a small shared instruction memory of address-tagged words.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br0;
  logic        br1;
  logic        ub;

  logic [63:0] addr0, addr1;
  logic [31:0] data0, data1;
  logic [31:0] instr0, instr1;
  logic [63:0] pcid0, pcid1;
  logic [63:0] tgt0, tgt1;

  logic [31:0] prog [64];

  int unsigned n_checks;
  int unsigned n_fail;

  fetch_unit #(
    .RESET_PC       (64'h0),
    .FLUSH_ON_BRANCH(1'b0),
    .NOP_WORD       (32'h0)
  ) dut_nf (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .BrTaken    (br0),
    .UncondBr   (ub),
    .imem_addr  (addr0),
    .imem_data  (data0),
    .instruction(instr0),
    .pc_id      (pcid0),
    .br_target  (tgt0)
  );

  fetch_unit #(
    .RESET_PC       (64'h0),
    .FLUSH_ON_BRANCH(1'b1),
    .NOP_WORD       (32'h0)
  ) dut_f (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .BrTaken    (br1),
    .UncondBr   (ub),
    .imem_addr  (addr1),
    .imem_data  (data1),
    .instruction(instr1),
    .pc_id      (pcid1),
    .br_target  (tgt1)
  );

  // Words outside the program window carry a DEAD tag with the low address bits.
  assign data0 = (addr0 < 64'd256) ? prog[addr0[7:2]] : (32'hDEAD_0000 | {16'h0, addr0[15:0]});
  assign data1 = (addr1 < 64'd256) ? prog[addr1[7:2]] : (32'hDEAD_0000 | {16'h0, addr1[15:0]});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_default();
    for (int i = 0; i < 64; i++) prog[i] = 32'hA000_0000 | 32'(i * 4);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    stall = 1'b0;
    br0   = 1'b0;
    br1   = 1'b0;
    ub    = 1'b0;
    load_default();
    step();
    step();
    check("rst_addr", addr0, 64'h0);
    check("rst_instr", {32'h0, instr0}, 64'h0);
    check("rst_pcid", pcid0, 64'h0);
    check("rst_instr_f", {32'h0, instr1}, 64'h0);

    // Sequential fetch, then B +3 at pc 8 with a B +2 in its delay slot.
    prog[2] = 32'h1400_0003;
    prog[3] = 32'h1400_0002;
    reset = 1'b0;
    step();
    check("seq1_addr", addr0, 64'd4);
    check("seq1_instr", {32'h0, instr0}, 64'hA000_0000);
    check("seq1_pcid", pcid0, 64'd0);
    step();
    check("seq2_addr", addr0, 64'd8);
    check("seq2_instr", {32'h0, instr0}, 64'hA000_0004);
    check("seq2_pcid", pcid0, 64'd4);
    step();
    check("seq3_addr", addr0, 64'd12);
    check("seq3_instr", {32'h0, instr0}, 64'h1400_0003);
    check("seq3_pcid", pcid0, 64'd8);
    br0 = 1'b1;
    br1 = 1'b1;
    ub  = 1'b1;
    #1;
    check("b_target", tgt0, 64'd20);
    check("b_target_f", tgt1, 64'd20);
    step();
    check("b_redirect", addr0, 64'd20);
    check("b_slot_instr", {32'h0, instr0}, 64'h1400_0002);
    check("b_slot_pcid", pcid0, 64'd12);
    check("bf_redirect", addr1, 64'd20);
    check("bf_nop", {32'h0, instr1}, 64'h0);
    check("bf_pcid", pcid1, 64'd12);
    br1 = 1'b0;
    check("slot_b_target", tgt0, 64'd20);
    step();
    br0 = 1'b0;
    check("slot_b_addr", addr0, 64'd20);
    check("slot_b_instr", {32'h0, instr0}, 64'hA000_0014);
    check("slot_b_pcid", pcid0, 64'd20);
    check("bf_after_addr", addr1, 64'd24);
    check("bf_after_instr", {32'h0, instr1}, 64'hA000_0014);
    check("bf_after_pcid", pcid1, 64'd20);

    // B.LT with imm19 = -2 at pc 16.
    reset = 1'b1;
    load_default();
    prog[4] = 32'h54FF_FFCB;
    step();
    reset = 1'b0;
    ub    = 1'b0;
    repeat (5) step();
    check("blt_pcid", pcid0, 64'd16);
    check("blt_instr", {32'h0, instr0}, 64'h54FF_FFCB);
    br0 = 1'b1;
    #1;
    check("blt_target", tgt0, 64'd8);
    step();
    br0 = 1'b0;
    check("blt_addr", addr0, 64'd8);
    check("blt_slot_pcid", pcid0, 64'd20);
    check("blt_slot_instr", {32'h0, instr0}, 64'hA000_0014);

    // Taken CBZ (+5 words) at pc 12 held by a 3-cycle stall.
    reset = 1'b1;
    load_default();
    prog[3] = 32'hB400_00A0;
    step();
    reset = 1'b0;
    repeat (4) step();
    check("cbz_pcid", pcid0, 64'd12);
    br0   = 1'b1;
    ub    = 1'b0;
    stall = 1'b1;
    #1;
    check("cbz_target", tgt0, 64'd32);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", addr0, 64'd16);
      check("stall_instr", {32'h0, instr0}, 64'hB400_00A0);
      check("stall_pcid", pcid0, 64'd12);
    end
    stall = 1'b0;
    step();
    br0 = 1'b0;
    check("cbz_redirect", addr0, 64'd32);
    check("cbz_slot_instr", {32'h0, instr0}, 64'hA000_0010);
    check("cbz_slot_pcid", pcid0, 64'd16);
    step();
    check("cbz_once_addr", addr0, 64'd36);
    check("cbz_once_pcid", pcid0, 64'd32);

    // Reset wins over a stalled taken branch.
    br0   = 1'b1;
    stall = 1'b1;
    reset = 1'b1;
    step();
    check("rst_mid_addr", addr0, 64'h0);
    check("rst_mid_instr", {32'h0, instr0}, 64'h0);
    check("rst_mid_pcid", pcid0, 64'h0);
    reset = 1'b0;
    stall = 1'b0;
    br0   = 1'b0;
    step();
    check("rst_resume_addr", addr0, 64'd4);
    check("rst_resume_instr", {32'h0, instr0}, 64'hA000_0000);

    // B -1 at pc 0 reaches the top word, then PC+4 wraps to 0.
    reset = 1'b1;
    load_default();
    prog[0] = 32'h17FF_FFFF;
    step();
    reset = 1'b0;
    step();
    check("wrap_b_instr", {32'h0, instr0}, 64'h17FF_FFFF);
    br0 = 1'b1;
    ub  = 1'b1;
    #1;
    check("wrap_target", tgt0, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    br0 = 1'b0;
    check("wrap_top_addr", addr0, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_top_pcid", pcid0, 64'd4);
    step();
    check("wrap_zero_addr", addr0, 64'h0);
    check("wrap_pcid", pcid0, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr", {32'h0, instr0}, 64'hDEAD_FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch (IF) stage of the pipelined LEGv8 processor; the producer end of the instruction interface that the control/decode stage consumes.
- Holds the program counter, drives the instruction-memory address and registers the fetched word into the IF/ID register (instruction, pc_id).
- Consumes the decode stage's BrTaken/UncondBr to redirect the PC, computing branch targets from the word currently in ID.
- Branches resolve in ID with one delay slot; the delay slot is optionally squashed.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
FLUSH_ON_BRANCH, 0, 0 = delay-slot instruction executes; 1 = delay-slot instruction replaced by NOP.
NOP_WORD, 32'h00000000, word loaded into IF/ID on reset/flush; decodes to no register/memory write.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hazard hold: freeze PC and IF/ID
BrTaken  in  1  from control, combinational decode of instruction (ID)
UncondBr  in  1  from control: 1 = B (imm26), 0 = CB-type (imm19)
imem_addr  out  64  instruction-memory address (= PC), combinational read
imem_data  in  32  instruction word at imem_addr, same cycle
instruction  out  32  IF/ID instruction register, feeds control
pc_id  out  64  address of instruction in ID
br_target  out  64  computed branch target (debug/verification)

Behaviour:
- State: PC[63:0], IF/ID {instruction, pc_id}. imem_addr = PC, combinational.
- Reset (reset=1 at posedge, wins over everything): PC<=RESET_PC, instruction<=NOP_WORD, pc_id<=RESET_PC. Reset asserted mid-stall or mid-branch discards the pending redirect.
- br_target (combinational, mod 2^64):
  - UncondBr=1: pc_id + (sext64(instruction[25:0]) << 2).
  - UncondBr=0: pc_id + (sext64(instruction[23:5]) << 2).
  - Computed every cycle; meaningful only when BrTaken=1.
- Next PC: BrTaken ? br_target : PC+4. PC+4 wraps at 2^64 silently.
- Normal cycle (reset=0, stall=0) at posedge: instruction<=imem_data, pc_id<=PC, PC<=next PC. Fetch-to-ID latency 1 cycle.
- Branch timing:
  - Branch in ID in cycle n → PC = target in cycle n+1.
  - The word fetched in cycle n (pc_id+4) enters ID in cycle n+1 as the delay slot.
  - FLUSH_ON_BRANCH=1: on a BrTaken cycle, instruction<=NOP_WORD and pc_id<=PC instead of the fetched word.
- Stall (reset=0, stall=1):
  - PC, instruction and pc_id hold.
  - Stall overrides BrTaken: the branch stays in ID and is re-evaluated after stall drops, so exactly one redirect occurs.
- A branch in the delay slot (FLUSH_ON_BRANCH=0) resolves normally the next cycle, using its own pc_id.
- No X on outputs after the first reset edge. BrTaken/UncondBr values before the first reset are don't-care.

Test Plan:
- Reset then sequential fetch, imem_data = addr-tagged words:
  - imem_addr = 0,4,8,12 on consecutive cycles.
  - instruction/pc_id lag by 1 cycle (pc_id = 0,4,8).
- B at pc_id=8 (instruction=32'h14000003, UncondBr=1, BrTaken=1):
  - br_target=20; next imem_addr=20.
  - FLUSH_ON_BRANCH=0: word from addr 12 appears in ID.
- B.LT at pc_id=16, imm19=19'h7FFFE (-2), UncondBr=0, BrTaken=1:
  - br_target=8; imem_addr=8 the following cycle.
- Same as the B case with FLUSH_ON_BRANCH=1: cycle after the branch, instruction=32'h0 and pc_id=12; then word@20 with pc_id=20.
- stall=1 for 3 cycles while a taken CBZ sits in ID:
  - PC/instruction/pc_id frozen throughout.
  - After release, exactly one redirect to the target.
- reset asserted for 1 cycle while BrTaken=1 and stall=1:
  - PC=RESET_PC, instruction=NOP_WORD; fetch resumes at 0.
  - PC=64'hFFFFFFFFFFFFFFFC sequential wraps to 0.
